// File: rtl/graphics_pkg.sv
// Shared display-path types: line-fill FSM encoding and slot-count helpers.
// Imported by the line prefetch controller and its slot tracker.
package graphics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    localparam int LINE_COUNT_POW_DEF = 1;
    localparam int LINE_SLOTS_DEF     = 2 ** LINE_COUNT_POW_DEF;

    function automatic int slot_count(input int pow);
        return 1 << pow;
    endfunction

endpackage

// File: rtl/line_slot_tracker.sv
// Line-buffer slot bookkeeping: write/read slot pointers, occupied count, underflow.
// Ports: clk, reset_n, commit (line filled), rel (display released), flush (frame_sync),
//        wr_slot, rd_slot, lines_ready, underflow (registered one-cycle pulse).
module line_slot_tracker
    import graphics_pkg::*;
#(
    parameter int LINE_COUNT_POW = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      commit,
    input  logic                      rel,
    input  logic                      flush,
    output logic [LINE_COUNT_POW-1:0] wr_slot,
    output logic [LINE_COUNT_POW-1:0] rd_slot,
    output logic [LINE_COUNT_POW:0]   lines_ready,
    output logic                      underflow
);

    logic empty;
    logic can_rel;

    assign empty   = (lines_ready == '0);
    assign can_rel = rel && !empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_slot     <= '0;
            rd_slot     <= '0;
            lines_ready <= '0;
            underflow   <= 1'b0;
        end else if (flush) begin
            wr_slot     <= '0;
            rd_slot     <= '0;
            lines_ready <= '0;
            underflow   <= 1'b0;
        end else begin
            underflow <= rel && empty;
            if (commit)
                wr_slot <= wr_slot + LINE_COUNT_POW'(1);
            if (can_rel)
                rd_slot <= rd_slot + LINE_COUNT_POW'(1);
            // Simultaneous commit and release cancel in the count.
            if (commit && !can_rel)
                lines_ready <= lines_ready + (LINE_COUNT_POW+1)'(1);
            else if (!commit && can_rel)
                lines_ready <= lines_ready - (LINE_COUNT_POW+1)'(1);
        end
    end

endmodule

// File: rtl/line_prefetch_ctrl.sv
// Fill side of the display line buffer: fetches frame rows and writes them into BRAM port A.
// Ports: frame_sync/start_next_line (display timing), fetch_req/row/ack (fetch engine),
//        pix_valid/data/ready (pixel stream), clka..dina (BRAM port A), rd_slot/lines_ready/underflow.
module line_prefetch_ctrl
    import graphics_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int LINE_COUNT_POW  = 1,
    parameter int PIXEL_COUNT_POW = 10,
    parameter int LINE_WIDTH      = 640,
    parameter int FRAME_LINES     = 480,
    parameter int ROW_POW         = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_sync,
    input  logic                      start_next_line,
    output logic                      fetch_req,
    output logic [ROW_POW-1:0]        fetch_row,
    input  logic                      fetch_ack,
    input  logic                      pix_valid,
    input  logic [DATA_WIDTH-1:0]     pix_data,
    output logic                      pix_ready,
    output logic                      clka,
    output logic                      rsta,
    output logic                      ena,
    output logic [DATA_WIDTH/8-1:0]   wea,
    output logic [ADDRESS_WIDTH-1:0]  addra,
    output logic [DATA_WIDTH-1:0]     dina,
    output logic [LINE_COUNT_POW-1:0] rd_slot,
    output logic [LINE_COUNT_POW:0]   lines_ready,
    output logic                      underflow
);

    localparam int SLOTS = slot_count(LINE_COUNT_POW);

    fill_state_t state, state_nxt;

    // One extra bit so row can reach FRAME_LINES even when it equals 2**ROW_POW.
    logic [ROW_POW:0]              row;
    logic [PIXEL_COUNT_POW-1:0]    pix_idx;
    logic [LINE_COUNT_POW-1:0]     wr_slot;
    logic                          commit;
    logic                          beat_acc;
    logic                          last_beat;
    logic                          can_fill;

    assign clka      = clk;
    assign rsta      = ~reset_n;
    assign fetch_row = row[ROW_POW-1:0];
    assign beat_acc  = pix_valid && pix_ready;
    assign last_beat = (pix_idx == PIXEL_COUNT_POW'(LINE_WIDTH - 1));
    assign can_fill  = (lines_ready < (LINE_COUNT_POW+1)'(SLOTS)) &&
                       (row < (ROW_POW+1)'(FRAME_LINES));

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        pix_ready = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: if (can_fill) state_nxt = ST_REQ;
            ST_REQ: begin
                fetch_req = 1'b1;
                if (fetch_ack) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                pix_ready = 1'b1;
                if (pix_valid && last_beat) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (frame_sync) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            row     <= '0;
            pix_idx <= '0;
            ena     <= 1'b0;
            wea     <= '0;
            addra   <= '0;
            dina    <= '0;
        end else begin
            state <= state_nxt;
            // A beat caught in the frame_sync cycle belongs to a discarded slot.
            ena <= beat_acc && !frame_sync;
            wea <= (beat_acc && !frame_sync) ? '1 : '0;
            if (beat_acc) begin
                addra <= ADDRESS_WIDTH'({wr_slot, pix_idx});
                dina  <= pix_data;
            end
            if (frame_sync)
                row <= '0;
            else if (commit)
                row <= row + (ROW_POW+1)'(1);
            if (state == ST_REQ)
                pix_idx <= '0;
            else if (beat_acc)
                pix_idx <= pix_idx + PIXEL_COUNT_POW'(1);
        end
    end

    line_slot_tracker #(
        .LINE_COUNT_POW(LINE_COUNT_POW)
    ) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .commit     (commit && !frame_sync),
        .rel        (start_next_line),
        .flush      (frame_sync),
        .wr_slot    (wr_slot),
        .rd_slot    (rd_slot),
        .lines_ready(lines_ready),
        .underflow  (underflow)
    );

endmodule

// File: tb/tb_line_prefetch_ctrl.sv
// Directed bench for line_prefetch_ctrl: a full-size instance for the fill/consume
// scenarios and a reduced-geometry instance that runs a whole frame.
module tb_line_prefetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    integer      checks = 0;
    integer      failures = 0;

    // Full-size instance
    logic        frame_sync, start_next_line, fetch_ack, pix_valid;
    logic [15:0] pix_data;
    logic        fetch_req, pix_ready, clka, rsta, ena, underflow;
    logic [9:0]  fetch_row;
    logic [1:0]  wea;
    logic [31:0] addra;
    logic [15:0] dina;
    logic [0:0]  rd_slot;
    logic [1:0]  lines_ready;

    // Reduced instance: 20-pixel lines, 12 rows
    logic        s_frame_sync, s_start_next_line, s_fetch_ack, s_pix_valid;
    logic [15:0] s_pix_data;
    logic        s_fetch_req, s_pix_ready, s_clka, s_rsta, s_ena, s_underflow;
    logic [3:0]  s_fetch_row;
    logic [1:0]  s_wea;
    logic [31:0] s_addra;
    logic [15:0] s_dina;
    logic [0:0]  s_rd_slot;
    logic [1:0]  s_lines_ready;
    integer      s_uf_cnt = 0;

    line_prefetch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync),
        .start_next_line(start_next_line), .fetch_req(fetch_req),
        .fetch_row(fetch_row), .fetch_ack(fetch_ack), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .clka(clka), .rsta(rsta),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .rd_slot(rd_slot),
        .lines_ready(lines_ready), .underflow(underflow)
    );

    line_prefetch_ctrl #(
        .PIXEL_COUNT_POW(5), .LINE_WIDTH(20), .FRAME_LINES(12), .ROW_POW(4)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .frame_sync(s_frame_sync),
        .start_next_line(s_start_next_line), .fetch_req(s_fetch_req),
        .fetch_row(s_fetch_row), .fetch_ack(s_fetch_ack), .pix_valid(s_pix_valid),
        .pix_data(s_pix_data), .pix_ready(s_pix_ready), .clka(s_clka), .rsta(s_rsta),
        .ena(s_ena), .wea(s_wea), .addra(s_addra), .dina(s_dina), .rd_slot(s_rd_slot),
        .lines_ready(s_lines_ready), .underflow(s_underflow)
    );

    always @(negedge clk) if (s_underflow) s_uf_cnt <= s_uf_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plays the fetch engine for one row: ack 2 cycles after fetch_req, then 640 beats.
    task automatic serve_main(input int base, input bit gaps,
                              output int row_seen, output int bad, output bit tmo);
        int n, k;
        bit acc;
        logic [15:0] d;
        bad = 0; tmo = 1'b0; row_seen = -1; n = 0;
        while (!fetch_req && n < 2000) begin tick(); n++; end
        if (!fetch_req) begin tmo = 1'b1; return; end
        row_seen = int'(fetch_row);
        repeat (2) begin
            tick();
            if (!fetch_req || int'(fetch_row) != row_seen) bad++;
        end
        fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
        k = 0; n = 0;
        while (k < 640 && n < 4000) begin
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = 16'(base + k) ^ 16'h5a5a;
            pix_data = d;
            acc = pix_valid && pix_ready;
            tick(); n++;
            if (acc) begin
                if (!ena || wea != 2'b11 || addra != 32'(base + k) || dina != d) bad++;
                k++;
            end else if (ena) bad++;
        end
        pix_valid = 1'b0;
        if (k < 640) tmo = 1'b1;
    endtask

    task automatic serve_small(input int base, output int row_seen,
                               output int bad, output bit tmo);
        int n, k;
        bit acc;
        logic [15:0] d;
        bad = 0; tmo = 1'b0; row_seen = -1; n = 0;
        while (!s_fetch_req && n < 2000) begin tick(); n++; end
        if (!s_fetch_req) begin tmo = 1'b1; return; end
        row_seen = int'(s_fetch_row);
        repeat (2) begin
            tick();
            if (!s_fetch_req || int'(s_fetch_row) != row_seen) bad++;
        end
        s_fetch_ack = 1'b1; tick(); s_fetch_ack = 1'b0;
        k = 0; n = 0;
        while (k < 20 && n < 400) begin
            s_pix_valid = ($urandom_range(0, 3) != 0);
            d = 16'(base + k + 7 * row_seen);
            s_pix_data = d;
            acc = s_pix_valid && s_pix_ready;
            tick(); n++;
            if (acc) begin
                if (!s_ena || s_wea != 2'b11 || s_addra != 32'(base + k) || s_dina != d) bad++;
                k++;
            end else if (s_ena) bad++;
        end
        s_pix_valid = 1'b0;
        if (k < 20) tmo = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (fetch_req !== 1'b0 || pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: fetch_req=%b pix_ready=%b want 0 0", fetch_req, pix_ready);
        end
        checks++;
        if (ena !== 1'b0 || wea !== 2'b00 || addra !== 32'd0 || dina !== 16'd0) begin
            failures++;
            $display("FAIL reset_bram: ena=%b wea=%b addra=%0d dina=%h want zeros",
                     ena, wea, addra, dina);
        end
        checks++;
        if (rd_slot !== 1'b0 || lines_ready !== 2'd0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_slots: rd=%b lr=%0d uf=%b want 0 0 0",
                     rd_slot, lines_ready, underflow);
        end
        checks++;
        if (rsta !== 1'b1 || clka !== clk) begin
            failures++;
            $display("FAIL reset_rsta: rsta=%b clka=%b want 1 %b", rsta, clka, clk);
        end
        reset_n = 1'b1;
        frame_sync = 1'b1; s_frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0; s_frame_sync = 1'b0;
        checks++;
        if (rsta !== 1'b0 || fetch_req !== 1'b0) begin
            failures++;
            $display("FAIL post_sync: rsta=%b fetch_req=%b want 0 0", rsta, fetch_req);
        end
    endtask

    task automatic test_fill_two;
        int rs, bad, seen;
        bit tmo;
        serve_main(0, 1'b0, rs, bad, tmo);
        checks++;
        if (tmo !== 1'b0 || rs !== 0 || bad !== 0) begin
            failures++;
            $display("FAIL fill0: row=%0d bad=%0d tmo=%b want 0 0 0", rs, bad, tmo);
        end
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill0_ready_drop: pix_ready=%b want 0", pix_ready);
        end
        tick();
        checks++;
        if (lines_ready !== 2'd1) begin
            failures++;
            $display("FAIL fill0_lr: lines_ready=%0d want 1", lines_ready);
        end
        serve_main(1024, 1'b0, rs, bad, tmo);
        checks++;
        if (tmo !== 1'b0 || rs !== 1 || bad !== 0) begin
            failures++;
            $display("FAIL fill1: row=%0d bad=%0d tmo=%b want 1 0 0", rs, bad, tmo);
        end
        tick();
        checks++;
        if (lines_ready !== 2'd2 || rd_slot !== 1'b0) begin
            failures++;
            $display("FAIL fill1_lr: lines_ready=%0d rd=%b want 2 0", lines_ready, rd_slot);
        end
        seen = 0;
        repeat (20) begin tick(); if (fetch_req) seen++; end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL full_block: fetch_req cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_release;
        int rs, bad;
        bit tmo;
        start_next_line = 1'b1; tick(); start_next_line = 1'b0;
        checks++;
        if (lines_ready !== 2'd1 || rd_slot !== 1'b1) begin
            failures++;
            $display("FAIL release: lines_ready=%0d rd=%b want 1 1", lines_ready, rd_slot);
        end
        tick();
        checks++;
        if (fetch_req !== 1'b1 || fetch_row !== 10'd2) begin
            failures++;
            $display("FAIL release_req: req=%b row=%0d want 1 2", fetch_req, fetch_row);
        end
        serve_main(0, 1'b0, rs, bad, tmo);
        tick();
        checks++;
        if (tmo !== 1'b0 || rs !== 2 || bad !== 0 || lines_ready !== 2'd2) begin
            failures++;
            $display("FAIL refill: row=%0d bad=%0d tmo=%b lr=%0d want 2 0 0 2",
                     rs, bad, tmo, lines_ready);
        end
    endtask

    task automatic test_underflow;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        checks++;
        if (lines_ready !== 2'd0 || rd_slot !== 1'b0 || fetch_req !== 1'b0) begin
            failures++;
            $display("FAIL flush: lr=%0d rd=%b req=%b want 0 0 0",
                     lines_ready, rd_slot, fetch_req);
        end
        start_next_line = 1'b1; tick(); start_next_line = 1'b0;
        checks++;
        if (underflow !== 1'b1 || lines_ready !== 2'd0 || rd_slot !== 1'b0) begin
            failures++;
            $display("FAIL underflow: uf=%b lr=%0d rd=%b want 1 0 0",
                     underflow, lines_ready, rd_slot);
        end
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pulse: uf=%b want 0", underflow);
        end
    endtask

    task automatic test_frame_sync_abort;
        int n, wr, rs, bad;
        bit tmo;
        n = 0;
        while (!fetch_req && n < 100) begin tick(); n++; end
        repeat (2) tick();
        fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
        for (int k = 0; k < 300; k++) begin
            pix_valid = 1'b1; pix_data = 16'(k); tick();
        end
        pix_data = 16'd300; frame_sync = 1'b1; tick(); frame_sync = 1'b0;
        checks++;
        if (pix_ready !== 1'b0 || lines_ready !== 2'd0 || fetch_req !== 1'b0 || ena !== 1'b0) begin
            failures++;
            $display("FAIL abort: ready=%b lr=%0d req=%b ena=%b want 0 0 0 0",
                     pix_ready, lines_ready, fetch_req, ena);
        end
        wr = 0;
        repeat (3) begin tick(); if (ena) wr++; end
        pix_valid = 1'b0;
        checks++;
        if (wr !== 0) begin
            failures++;
            $display("FAIL abort_drop: writes=%0d want 0", wr);
        end
        serve_main(0, 1'b1, rs, bad, tmo);
        tick();
        checks++;
        if (tmo !== 1'b0 || rs !== 0 || bad !== 0 || lines_ready !== 2'd1) begin
            failures++;
            $display("FAIL abort_refill: row=%0d bad=%0d tmo=%b lr=%0d want 0 0 0 1",
                     rs, bad, tmo, lines_ready);
        end
    endtask

    task automatic test_coincident;
        int rs, bad;
        bit tmo;
        serve_main(1024, 1'b0, rs, bad, tmo);
        start_next_line = 1'b1; tick(); start_next_line = 1'b0;
        checks++;
        if (tmo !== 1'b0 || rs !== 1 || bad !== 0) begin
            failures++;
            $display("FAIL coinc_fill: row=%0d bad=%0d tmo=%b want 1 0 0", rs, bad, tmo);
        end
        checks++;
        if (lines_ready !== 2'd1 || rd_slot !== 1'b1 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL coinc: lr=%0d rd=%b uf=%b want 1 1 0",
                     lines_ready, rd_slot, underflow);
        end
        serve_main(0, 1'b0, rs, bad, tmo);
        tick();
        checks++;
        if (tmo !== 1'b0 || rs !== 2 || bad !== 0 || lines_ready !== 2'd2) begin
            failures++;
            $display("FAIL coinc_wrap: row=%0d bad=%0d tmo=%b lr=%0d want 2 0 0 2",
                     rs, bad, tmo, lines_ready);
        end
    endtask

    task automatic test_full_frame;
        int uf0, row_err, bad_sum, tmo_cnt, last_row, seen, n;
        bit cons_tmo;
        row_err = 0; bad_sum = 0; tmo_cnt = 0; last_row = -1; cons_tmo = 1'b0;
        s_frame_sync = 1'b1; tick(); s_frame_sync = 1'b0;
        uf0 = s_uf_cnt;
        fork
            begin
                for (int r = 0; r < 12; r++) begin
                    int rs, b;
                    bit t;
                    serve_small((r % 2) * 32, rs, b, t);
                    if (rs != r) row_err++;
                    bad_sum += b;
                    if (t) tmo_cnt++;
                    last_row = rs;
                end
            end
            begin
                int w;
                w = 0;
                while (s_lines_ready != 2'd2 && w < 1000) begin tick(); w++; end
                if (s_lines_ready != 2'd2) cons_tmo = 1'b1;
                repeat (12) begin
                    repeat (39) tick();
                    s_start_next_line = 1'b1; tick(); s_start_next_line = 1'b0;
                end
            end
        join
        tick();
        checks++;
        if (s_uf_cnt - uf0 !== 0 || cons_tmo !== 1'b0) begin
            failures++;
            $display("FAIL frame_underflow: pulses=%0d cons_tmo=%b want 0 0",
                     s_uf_cnt - uf0, cons_tmo);
        end
        checks++;
        if (row_err !== 0 || bad_sum !== 0 || tmo_cnt !== 0) begin
            failures++;
            $display("FAIL frame_rows: row_err=%0d bad=%0d tmo=%0d want 0 0 0",
                     row_err, bad_sum, tmo_cnt);
        end
        checks++;
        if (last_row !== 11 || s_lines_ready !== 2'd0 || s_rd_slot !== 1'b0) begin
            failures++;
            $display("FAIL frame_end: last=%0d lr=%0d rd=%b want 11 0 0",
                     last_row, s_lines_ready, s_rd_slot);
        end
        seen = 0;
        repeat (30) begin tick(); if (s_fetch_req) seen++; end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL frame_stop: fetch_req cycles=%0d want 0", seen);
        end
        s_frame_sync = 1'b1; tick(); s_frame_sync = 1'b0;
        n = 0;
        while (!s_fetch_req && n < 5) begin tick(); n++; end
        checks++;
        if (s_fetch_req !== 1'b1 || s_fetch_row !== 4'd0) begin
            failures++;
            $display("FAIL frame_restart: req=%b row=%0d want 1 0", s_fetch_req, s_fetch_row);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        frame_sync = 1'b0; start_next_line = 1'b0; fetch_ack = 1'b0;
        pix_valid = 1'b0; pix_data = '0;
        s_frame_sync = 1'b0; s_start_next_line = 1'b0; s_fetch_ack = 1'b0;
        s_pix_valid = 1'b0; s_pix_data = '0;
        test_reset();
        test_fill_two();
        test_release();
        test_underflow();
        test_frame_sync_abort();
        test_coincident();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
